// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter for the single register-file write port, shared by
//   NREQ writeback requesters. The winning write is registered for one cycle
//   before it reaches the regfile. The block also keeps a per-register busy
//   scoreboard, so the issue stage can stall on RAW and WAW hazards.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   req_valid/ready   per-requester handshake; ready is a one-hot grant
//   req_rd, req_wdata packed per-requester destination and data (slice i)
//   rsv_valid/rd      issue-stage reservation of a destination register
//   rsv_ready         reservation accepted (destination not already busy)
//   rs1, rs2          source addresses; rs1_busy/rs2_busy are busy lookups
//   rf_we/rd/wdata    registered write port toward the regfile
//   busy              full scoreboard vector (bit 0 is always 0)
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_wdata,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_rd,
  output logic                 rsv_ready,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [2**AW-1:0]     busy
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 2**AW;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic [NREQ-1:0] grant_oh;
  logic [PW-1:0]   grant_idx;
  logic            grant_found;
  logic            xfer;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_wdata;
  logic            rsv_fire;

  // Scan from the pointer forward, wrapping, and take the first valid requester.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found   = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = PW'(idx);
      end
    end
  end

  // The grant is forced low while reset is held.
  assign req_ready = rst_n ? grant_oh : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_rd    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_rd    = req_rd[i*AW +: AW];
        sel_wdata = req_wdata[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = PW'((int'(grant_idx) + 1) % NREQ);
  end

  // A write to x0 completes the handshake but never reaches the regfile.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer && (sel_rd != '0)) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = sel_rd;
      rf_wdata_d = sel_wdata;
    end
  end

  // There is no bypass of a clear that happens on the same edge. The
  // reservation stalls one extra cycle and retries.
  assign rsv_ready = (rsv_rd == '0) || !busy_q[rsv_rd];
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_rd != '0);

  // Apply the clear first, so a set on the same register and edge wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_rd_q] = 1'b0;
    if (rsv_fire) busy_d[rsv_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

endmodule
